// File: rtl/demultiplexer_8_reg.sv
// Registered 1-to-8 demultiplexer: one source fanned out to eight lanes, each with
// its own holding register and valid/ack handshake. Target lane comes from sel or a round-robin pointer.

module demultiplexer_8_reg_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A load on the same edge as an ack wins: the lane stays full with the new word.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (ack_i && valid_q) valid_d = 1'b0;
        if (load_i) begin
            data_d  = din_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

module demultiplexer_8_reg #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               autoMode,
    input  logic [2:0]         sel,
    input  logic [WIDTH-1:0]   demuxIn,
    input  logic               inValid,
    output logic               inReady,
    output logic [8*WIDTH-1:0] demuxOut,
    output logic [7:0]         outValid,
    input  logic [7:0]         outAck,
    output logic [2:0]         ptrOut
);
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] tgt;
    logic       accept;
    logic [7:0] load;

    assign tgt     = autoMode ? ptr_q : sel;
    // A full lane being acked this cycle can take a new word on the same edge.
    assign inReady = enable & (~outValid[tgt] | outAck[tgt]);
    assign accept  = inValid & inReady;

    always_comb begin
        load = '0;
        if (accept) load[tgt] = 1'b1;
    end

    // Pointer never skips a stalled lane; it only moves on an accepted word in auto mode.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && autoMode) ptr_d = ptr_q + 3'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptrOut = ptr_q;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        demultiplexer_8_reg_lane #(.WIDTH(WIDTH)) u_lane (
            .clock   (clock),
            .reset   (reset),
            .load_i  (load[g]),
            .ack_i   (outAck[g]),
            .din_i   (demuxIn),
            .data_o  (demuxOut[g*WIDTH +: WIDTH]),
            .valid_o (outValid[g])
        );
    end
endmodule

// File: tb/tb_demultiplexer_8_reg.sv
// Bench for demultiplexer_8_reg: array-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_demultiplexer_8_reg;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        autoMode = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [7:0]  demuxIn = 8'h00;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [63:0] demuxOut;
    logic [7:0]  outValid;
    logic [7:0]  outAck = 8'h00;
    logic [2:0]  ptrOut;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference state
    logic [7:0] lane_m [8];
    bit         vld_m  [8];
    int         ptr_m = 0;

    demultiplexer_8_reg #(.WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .autoMode (autoMode),
        .sel      (sel),
        .demuxIn  (demuxIn),
        .inValid  (inValid),
        .inReady  (inReady),
        .demuxOut (demuxOut),
        .outValid (outValid),
        .outAck   (outAck),
        .ptrOut   (ptrOut)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            lane_m[i] = 8'h00;
            vld_m[i]  = 1'b0;
        end
    end

    // Model: acks clear full lanes, an accepted word lands in the target lane.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                lane_m[i] = 8'h00;
                vld_m[i]  = 1'b0;
            end
            ptr_m = 0;
        end else begin
            int  t;
            bit  acc;
            t   = autoMode ? ptr_m : int'(sel);
            acc = inValid && enable && (!vld_m[t] || outAck[t]);
            for (int i = 0; i < 8; i++)
                if (vld_m[i] && outAck[i]) vld_m[i] = 1'b0;
            if (acc) begin
                lane_m[t] = demuxIn;
                vld_m[t]  = 1'b1;
                if (autoMode) ptr_m = (ptr_m + 1) % 8;
            end
        end
    end

    always @(negedge clock) begin
        logic [63:0] exp_out;
        logic [7:0]  exp_vld;
        int          t;
        for (int i = 0; i < 8; i++) begin
            exp_out[i*8 +: 8] = lane_m[i];
            exp_vld[i]        = vld_m[i];
        end
        t = autoMode ? ptr_m : int'(sel);
        check("model demuxOut", demuxOut, exp_out);
        check("model outValid", {56'd0, outValid}, {56'd0, exp_vld});
        check("model ptrOut", {61'd0, ptrOut}, 64'(ptr_m));
        check("model inReady", {63'd0, inReady},
              {63'd0, enable && (!vld_m[t] || outAck[t])});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] lane(input int i);
        return {56'd0, demuxOut[i*8 +: 8]};
    endfunction

    initial begin
        tick(); tick();
        #1;
        check("reset outValid", {56'd0, outValid}, 64'h0);
        check("reset demuxOut", demuxOut, 64'h0);
        check("reset ptrOut", {61'd0, ptrOut}, 64'h0);
        reset = 1'b0; enable = 1'b1;
        tick();

        // Explicit select to lane 5
        autoMode = 1'b0; sel = 3'd5; demuxIn = 8'hA5; inValid = 1'b1;
        #1 check("sel5 inReady", {63'd0, inReady}, 64'h1);
        tick();
        inValid = 1'b0;
        #1 check("sel5 outValid", {56'd0, outValid}, 64'h20);
        check("sel5 lane5", lane(5), 64'hA5);
        outAck = 8'h20;
        tick();
        outAck = 8'h00;
        #1 check("ack5 outValid", {56'd0, outValid}, 64'h0);
        check("ack5 lane5 held", lane(5), 64'hA5);

        // Fill lanes 0-2 then reset between edges
        autoMode = 1'b1; inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            demuxIn = 8'h40 + 8'(i);
            tick();
        end
        inValid = 1'b0;
        #1 check("pre-reset outValid", {56'd0, outValid}, 64'h07);
        check("pre-reset ptrOut", {61'd0, ptrOut}, 64'h3);
        reset = 1'b1;
        #1 check("async reset outValid", {56'd0, outValid}, 64'h0);
        check("async reset demuxOut", demuxOut, 64'h0);
        check("async reset ptrOut", {61'd0, ptrOut}, 64'h0);
        tick();
        reset = 1'b0;
        tick();

        // Round-robin with wrap and stall on lane 0
        inValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            demuxIn = 8'h10 + 8'(i);
            #1 check("rr inReady", {63'd0, inReady}, 64'h1);
            tick();
        end
        demuxIn = 8'h18;
        #1 check("rr full outValid", {56'd0, outValid}, 64'hFF);
        check("rr lanes", demuxOut, 64'h1716151413121110);
        check("rr stall ptrOut", {61'd0, ptrOut}, 64'h0);
        for (int i = 0; i < 2; i++) begin
            check("rr stall inReady", {63'd0, inReady}, 64'h0);
            tick();
        end
        outAck = 8'h01;
        #1 check("rr ack inReady", {63'd0, inReady}, 64'h1);
        tick();
        outAck = 8'h00; inValid = 1'b0;
        #1 check("rr reload lane0", lane(0), 64'h18);
        check("rr reload outValid", {56'd0, outValid}, 64'hFF);
        check("rr reload ptrOut", {61'd0, ptrOut}, 64'h1);

        // Explicit backpressure on lane 3, then same-edge reload
        autoMode = 1'b0; sel = 3'd3; demuxIn = 8'h3C; inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("bp inReady", {63'd0, inReady}, 64'h0);
            tick();
        end
        check("bp lane3 held", lane(3), 64'h13);
        outAck = 8'h08;
        #1 check("bp ack inReady", {63'd0, inReady}, 64'h1);
        tick();
        outAck = 8'h00; inValid = 1'b0;
        #1 check("bp reload lane3", lane(3), 64'h3C);
        check("bp reload outValid", {56'd0, outValid}, 64'hFF);

        // Enable low: no accepts, acks still clear
        enable = 1'b0; autoMode = 1'b1; inValid = 1'b1; demuxIn = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            #1 check("en0 inReady", {63'd0, inReady}, 64'h0);
            check("en0 ptrOut", {61'd0, ptrOut}, 64'h1);
            tick();
        end
        outAck = 8'h42;
        tick();
        outAck = 8'h00;
        #1 check("en0 ack outValid", {56'd0, outValid}, 64'hBD);
        check("en0 lane1 held", lane(1), 64'h11);
        check("en0 lane6 held", lane(6), 64'h16);

        // Spurious ack on an empty lane
        outAck = 8'h10;
        tick();
        outAck = 8'h10;
        tick();
        outAck = 8'h00;
        #1 check("spurious ack outValid", {56'd0, outValid}, 64'hAD);

        // Move pointer to 3: fill empty lane 1, then reload lane 2 with ack
        enable = 1'b1; demuxIn = 8'h21;
        tick();
        demuxIn = 8'h22; outAck = 8'h04;
        tick();
        outAck = 8'h00; inValid = 1'b0;
        #1 check("ptr at 3", {61'd0, ptrOut}, 64'h3);
        check("lane2 reload", lane(2), 64'h22);
        autoMode = 1'b0;
        tick();
        autoMode = 1'b1;
        tick();
        #1 check("mode toggle ptrOut", {61'd0, ptrOut}, 64'h3);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/demultiplexer_8_reg.md
Name: demultiplexer_8_reg

Overview:
Registered 1-to-8 demultiplexer with per-lane holding registers and a valid/ready handshake. It distributes a shared source word to one of eight destination lanes. The lane is picked by an explicit select or by an internal round-robin pointer. It sits on the far side of the 8:1 selection path and fans one producer out to eight consumers, each of which acknowledges independently.

Parameters:
WIDTH, 8, data width of the input word and of each output lane.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  when low, no new words are accepted. Acks still processed.
autoMode  input  1  1: target lane = internal pointer; 0: target lane = sel.
sel  input  3  explicit target lane when autoMode=0.
demuxIn  input  WIDTH  source data word.
inValid  input  1  source presents a word this cycle.
inReady  output  1  block can accept a word for the current target lane (combinational).
demuxOut  output  8*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]; registered.
outValid  output  8  bit i set = lane i holds an unconsumed word; registered.
outAck  input  8  bit i: consumer i takes lane i this cycle.
ptrOut  output  3  current round-robin pointer value.

Behaviour:
- Reset (asynchronous, immediate):
  - All demuxOut lanes = 0.
  - outValid = 8'h00.
  - Pointer = 0.
  - inReady follows its combinational definition.
  - A reset during a transfer discards the word; no partial lane update.
- Target lane: tgt = autoMode ? ptr : sel.
- inReady = enable & (~outValid[tgt] | outAck[tgt]). This means a full lane that is acked in the same cycle accepts a new word (pass-through reload).
- Accept = inValid & inReady. On accept at the clock edge:
  - lane[tgt] <= demuxIn.
  - outValid[tgt] <= 1.
- Latency: one cycle from the accept edge to the word visible on demuxOut with outValid set.
- Ack: for each lane i with outValid[i]=1 and outAck[i]=1, outValid[i] <= 0 unless the same edge also accepts into lane i (then it stays 1 and holds the new word).
- Ack to a lane whose outValid=0 is ignored.
- Acks on multiple lanes in one cycle are all honoured.
- Lane data is held after ack (not cleared). Only outValid drops.
- Pointer:
  - Advances by 1 only on an accept while autoMode=1.
  - Wraps from 7 to 0.
  - Holds in all other cases, including while autoMode=0.
  - Toggling autoMode does not reset it.
- Pointer backpressure: in autoMode, a full, unacked lane at ptr stalls the source. The pointer never skips to another lane.
- enable low:
  - inReady=0 and no accepts; pointer holds.
  - Lane contents and outValid hold except for ack clearing.
- inValid without inReady: no state change. The source must hold its word (standard valid/ready; the block does not require stability, it simply samples on accept).
- sel and autoMode changes take effect combinationally on tgt and inReady in the same cycle.

Test Plan:
1. Reset mid-stream: fill lanes 0-2, assert reset asynchronously between edges -> outValid=00, all demuxOut=0, ptrOut=0 immediately, before the next edge.
2. Explicit select: autoMode=0, sel=5, demuxIn=8'hA5, inValid=1 -> inReady=1. Next cycle outValid=8'h20, lane5=A5. Ack bit5 -> outValid=00, lane5 still A5.
3. Round-robin with wrap: autoMode=1, 9 back-to-back words 8'h10..8'h18, no acks until the 9th -> lanes 0..7 = 10..17 and outValid=FF. The 9th word stalls with inReady=0 and ptrOut=0. Ack lane0 -> the 9th word (18) loads lane0 on that edge, outValid stays FF, ptrOut=1.
4. Backpressure, explicit: lane3 full, sel=3, inValid=1, no ack -> inReady=0 for 4 cycles, lane3 unchanged. Assert outAck[3] with inValid=1, demuxIn=8'h3C -> same-edge reload, lane3=3C, outValid[3] stays 1.
5. Enable low: enable=0, inValid=1, autoMode=1 -> inReady=0, ptrOut constant. Ack on lanes 1 and 6 together -> both outValid bits clear; lanes 1 and 6 hold their data.
6. Spurious ack and mode switch: ack lane 4 while outValid[4]=0 -> no change. Switch autoMode 1->0->1 with ptrOut=3 and no accepts -> ptrOut stays 3.
